// File: rtl/buffer_pkg.sv
// Shared sizing helpers and default-configuration types for the narrow-to-wide upsizing buffer.
package buffer_pkg;

  localparam int IN_W_DEF  = 64;
  localparam int OUT_W_DEF = 512;
  localparam int DEPTH_DEF = 4;

  function automatic int calc_ratio(input int out_w, input int in_w);
    return out_w / in_w;
  endfunction

  // Lane counters must also hold RATIO itself (a full word's out_lanes).
  function automatic int lane_w(input int ratio);
    return $clog2(ratio + 1);
  endfunction

  localparam int RATIO_DEF  = calc_ratio(OUT_W_DEF, IN_W_DEF);
  localparam int LANE_W_DEF = lane_w(RATIO_DEF);

  typedef logic [LANE_W_DEF-1:0] lane_cnt_t;

  typedef struct packed {
    logic [OUT_W_DEF-1:0] data;
    lane_cnt_t            lanes;
  } fifo_entry_t;

endpackage

// File: rtl/sync_fifo_fwft.sv
// First-word-fall-through FIFO: head entry is visible on rdata whenever the FIFO is non-empty.
module sync_fifo_fwft #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       clr,
  input  logic                       push,
  input  logic                       pop,
  input  logic [WIDTH-1:0]           wdata,
  output logic [WIDTH-1:0]           rdata,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("sync_fifo_fwft: DEPTH must be a power of two and at least 2");
  end

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             pop_act;
  logic             push_act;

  always_comb begin
    pop_act  = pop & (count_q != '0);
    push_act = push & ((count_q != DEPTH_C) | pop_act);
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (clr) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_act) begin
        mem_d[wr_ptr_q] = wdata;
        wr_ptr_d        = wr_ptr_q + PTR_W'(1);
      end
      if (pop_act) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      case ({push_act, pop_act})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: stale contents are never visible while empty.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign empty = (count_q == '0);
  assign count = count_q;
  assign rdata = empty ? '0 : mem_q[rd_ptr_q];

  always @(posedge clk) begin
    if (rst) begin
      assert (count_q <= DEPTH_C);
      assert (!(push && !pop_act && count_q == DEPTH_C));
    end
  end

endmodule

// File: rtl/buffer_upsize_fifo.sv
// Packs IN_W-bit writes into OUT_W-bit words (lane 0 at LSBs) and queues them with a lane count in a FWFT FIFO.
module buffer_upsize_fifo
  import buffer_pkg::*;
#(
  parameter int IN_W  = IN_W_DEF,
  parameter int OUT_W = OUT_W_DEF,
  parameter int DEPTH = DEPTH_DEF
) (
  input  logic                                         clk,
  input  logic                                         rst,
  input  logic                                         clr,
  input  logic [IN_W-1:0]                              data_in,
  input  logic                                         wr_enable,
  input  logic                                         flush,
  input  logic                                         rd_enable,
  output logic [OUT_W-1:0]                             data_out,
  output logic [lane_w(calc_ratio(OUT_W, IN_W))-1:0]   out_lanes,
  output logic [$clog2(DEPTH+1)-1:0]                   count,
  output logic                                         full,
  output logic                                         full_n,
  output logic                                         empty
);

  localparam int RATIO  = calc_ratio(OUT_W, IN_W);
  localparam int LANE_W = lane_w(RATIO);
  localparam int CNT_W  = $clog2(DEPTH + 1);
  localparam int ENT_W  = OUT_W + LANE_W;
  localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(RATIO - 1);
  localparam logic [CNT_W-1:0]  DEPTH_C   = CNT_W'(DEPTH);

  if ((OUT_W % IN_W) != 0 || (OUT_W / IN_W) < 2) begin : g_bad_ratio
    $error("buffer_upsize_fifo: OUT_W must be a multiple of IN_W with RATIO >= 2");
  end

  logic [OUT_W-1:0]  asm_q, asm_d, asm_w;
  logic [LANE_W-1:0] lane_cnt_q, lane_cnt_d, lanes_w;
  logic              room;
  logic              wr_acc;
  logic              word_done;
  logic              flush_go;
  logic              push;
  logic [ENT_W-1:0]  head;

  // Room exists if the FIFO has a free slot or the head is leaving this same edge.
  assign room   = (count < DEPTH_C) | (rd_enable & ~empty);
  assign full   = (lane_cnt_q == LAST_LANE) & ~room;
  assign full_n = ~full;

  always_comb begin
    wr_acc = wr_enable & ~full;
    asm_w  = asm_q;
    for (int i = 0; i < RATIO; i++) begin
      if (wr_acc && lane_cnt_q == LANE_W'(i)) begin
        asm_w[i*IN_W +: IN_W] = data_in;
      end
    end
    lanes_w    = lane_cnt_q + {{(LANE_W-1){1'b0}}, wr_acc};
    word_done  = wr_acc & (lane_cnt_q == LAST_LANE);
    flush_go   = flush & (lanes_w != '0) & room;
    push       = ~clr & (word_done | flush_go);
    asm_d      = asm_w;
    lane_cnt_d = lanes_w;
    if (clr || push) begin
      asm_d      = '0;
      lane_cnt_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      asm_q      <= '0;
      lane_cnt_q <= '0;
    end else begin
      asm_q      <= asm_d;
      lane_cnt_q <= lane_cnt_d;
    end
  end

  sync_fifo_fwft #(
    .WIDTH (ENT_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .clr   (clr),
    .push  (push),
    .pop   (rd_enable),
    .wdata ({asm_w, lanes_w}),
    .rdata (head),
    .count (count),
    .empty (empty)
  );

  assign data_out  = head[ENT_W-1:LANE_W];
  assign out_lanes = head[LANE_W-1:0];

endmodule

// File: tb/tb_buffer_upsize_fifo.sv
// Randomised and directed bench for buffer_upsize_fifo against a queue-based reference model.
module tb_buffer_upsize_fifo;
  import buffer_pkg::*;

  localparam int IN_W  = 64;
  localparam int OUT_W = 512;
  localparam int DEPTH = 4;
  localparam int RATIO = 8;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            clr = 1'b0;
  logic [IN_W-1:0] data_in = '0;
  logic            wr_enable = 1'b0;
  logic            flush = 1'b0;
  logic            rd_enable = 1'b0;
  logic [OUT_W-1:0] data_out;
  logic [3:0]      out_lanes;
  logic [2:0]      count;
  logic            full, full_n, empty;

  int total = 0;
  int bad   = 0;

  fifo_entry_t     mq[$];
  logic [IN_W-1:0] part[$];

  always #5 clk = ~clk;

  buffer_upsize_fifo #(.IN_W(IN_W), .OUT_W(OUT_W), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .clr       (clr),
    .data_in   (data_in),
    .wr_enable (wr_enable),
    .flush     (flush),
    .rd_enable (rd_enable),
    .data_out  (data_out),
    .out_lanes (out_lanes),
    .count     (count),
    .full      (full),
    .full_n    (full_n),
    .empty     (empty)
  );

  task automatic chk(input string tag, input logic [575:0] got, input logic [575:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic bit model_room(input bit r);
    return (mq.size() < DEPTH) || (r && mq.size() > 0);
  endfunction

  function automatic bit model_full(input bit r);
    return (part.size() == RATIO - 1) && !model_room(r);
  endfunction

  task automatic check_outputs();
    bit exp_full;
    exp_full = model_full(rd_enable);
    chk("full", 576'(full), 576'(exp_full));
    chk("full_n", 576'(full_n), 576'(!exp_full));
    chk("count", 576'(count), 576'(mq.size()));
    chk("empty", 576'(empty), 576'(mq.size() == 0));
    if (mq.size() > 0) begin
      chk("data_out", 576'(data_out), 576'(mq[0].data));
      chk("out_lanes", 576'(out_lanes), 576'(mq[0].lanes));
    end else begin
      chk("data_out_empty", 576'(data_out), 576'(0));
      chk("out_lanes_empty", 576'(out_lanes), 576'(0));
    end
  endtask

  task automatic model_update(input bit c, input bit w, input logic [IN_W-1:0] d, input bit f, input bit r);
    bit room, fl, do_push;
    fifo_entry_t e;
    if (c) begin
      mq.delete();
      part.delete();
      return;
    end
    room = model_room(r);
    fl   = model_full(r);
    if (w && !fl) part.push_back(d);
    do_push = (part.size() == RATIO) || (f && part.size() > 0 && room);
    if (r && mq.size() > 0) void'(mq.pop_front());
    if (do_push) begin
      e.data = '0;
      foreach (part[i]) e.data[i*IN_W +: IN_W] = part[i];
      e.lanes = 4'(part.size());
      mq.push_back(e);
      part.delete();
    end
  endtask

  task automatic step(input bit c, input bit w, input logic [IN_W-1:0] d, input bit f, input bit r);
    @(negedge clk);
    clr = c; wr_enable = w; data_in = d; flush = f; rd_enable = r;
    #1;
    check_outputs();
    @(posedge clk);
    model_update(c, w, d, f, r);
  endtask

  task automatic wr(input logic [IN_W-1:0] d);
    step(1'b0, 1'b1, d, 1'b0, 1'b0);
  endtask

  task automatic idle_rd(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, '0, 1'b0, 1'b1);
  endtask

  task automatic reset_mid();
    @(negedge clk);
    clr = 0; wr_enable = 0; flush = 0; rd_enable = 0; data_in = '0;
    #3;
    rst = 1'b0;
    #1;
    mq.delete();
    part.delete();
    check_outputs();
    @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    logic [OUT_W-1:0] exp_word;
    int thr_rd;

    // Reset asserted mid-cycle at 23 ns
    #23;
    rst = 1'b0;
    #1;
    check_outputs();
    chk("rst_full_n", 576'(full_n), 576'(1));
    @(negedge clk);
    rst = 1'b1;

    // One full word from writes 1..8
    for (int i = 1; i <= 8; i++) wr(64'(i));
    #1;
    exp_word = '0;
    for (int i = 0; i < RATIO; i++) exp_word[i*IN_W +: IN_W] = 64'(i + 1);
    chk("t2_count", 576'(count), 576'(1));
    chk("t2_empty", 576'(empty), 576'(0));
    chk("t2_lanes", 576'(out_lanes), 576'(8));
    chk("t2_word", 576'(data_out), 576'(exp_word));
    idle_rd(1);

    // Partial word flush, then a no-op flush
    for (int i = 1; i <= 3; i++) wr(64'(i));
    step(1'b0, 1'b0, '0, 1'b1, 1'b0);
    #1;
    exp_word = '0;
    for (int i = 0; i < 3; i++) exp_word[i*IN_W +: IN_W] = 64'(i + 1);
    chk("t3_lanes", 576'(out_lanes), 576'(3));
    chk("t3_word", 576'(data_out), 576'(exp_word));
    step(1'b0, 1'b0, '0, 1'b1, 1'b0);
    #1;
    chk("t3_noop_count", 576'(count), 576'(1));
    idle_rd(1);

    // Fill to DEPTH, block lane 7, then release with a read
    for (int i = 1; i <= 40; i++) wr(64'(i));
    #1;
    chk("t4_count", 576'(count), 576'(4));
    chk("t4_full", 576'(full), 576'(1));
    idle_rd(1);
    wr(64'd40);
    #1;
    chk("t4_refill", 576'(count), 576'(4));

    // Simultaneous completing write and read at DEPTH
    for (int i = 41; i <= 47; i++) wr(64'(i));
    step(1'b0, 1'b1, 64'd48, 1'b0, 1'b1);
    #1;
    chk("t5_count", 576'(count), 576'(4));
    chk("t5_head", 576'(data_out[63:0]), 576'(17));
    idle_rd(5);

    // Synchronous clear mid-word
    for (int i = 1; i <= 21; i++) wr(64'(i));
    step(1'b1, 1'b0, '0, 1'b0, 1'b0);
    #1;
    chk("t6_clr_count", 576'(count), 576'(0));
    chk("t6_clr_empty", 576'(empty), 576'(1));
    for (int i = 0; i < 8; i++) wr(64'(100 + i));
    #1;
    chk("t6_clean_lanes", 576'(out_lanes), 576'(8));
    chk("t6_clean_lane0", 576'(data_out[63:0]), 576'(100));
    idle_rd(1);

    // Asynchronous reset mid-word
    for (int i = 1; i <= 21; i++) wr(64'(i));
    reset_mid();
    chk("t6_rst_count", 576'(count), 576'(0));
    for (int i = 0; i < 8; i++) wr(64'(200 + i));
    #1;
    chk("t6_rst_lane0", 576'(data_out[63:0]), 576'(200));
    idle_rd(1);

    // Random traffic, alternating read-heavy and read-starved phases
    for (int i = 0; i < 3000; i++) begin
      thr_rd = ((i / 300) % 2 == 0) ? 60 : 12;
      step($urandom_range(0, 99) < 2,
           $urandom_range(0, 99) < 65,
           {$urandom(), $urandom()},
           $urandom_range(0, 99) < 8,
           $urandom_range(0, 99) < thr_rd);
    end
    step(1'b0, 1'b0, '0, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
